// File: rtl/or3_chk_pkg.sv
// Shared types and helpers for the 3-input OR response checker.
package or3_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } chk_state_t;

   localparam int NUM_COMBOS = 8;

   // Reference model of the gate under test.
   function automatic logic exp_or(input logic a, input logic b, input logic c);
      return a | b | c;
   endfunction

endpackage

// File: rtl/or3_chk_cov.sv
// Coverage bitmap of the 8 input combinations seen during a run.
// Only instantiated when OR3_CHK_COVERAGE_EN is defined.
module or3_chk_cov
   import or3_chk_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  set_en,
   input  logic [2:0]            sel,
   output logic [NUM_COMBOS-1:0] cov_map,
   output logic                  all_covered
);

   // Clear at the start of a run, then mark each combination as it is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cov_map <= '0;
      end else if (clear) begin
         cov_map <= '0;
      end else if (set_en) begin
         cov_map[sel] <= 1'b1;
      end
   end

   assign all_covered = &cov_map;

endmodule

// File: rtl/or3_vector_checker.sv
// Response checker for the 3-input OR gate: compares each presented
// response against the expected OR, counts mismatches, tracks coverage
// and reports pass/fail after VEC_COUNT vectors.
// Optional feature macro: OR3_CHK_COVERAGE_EN (coverage tracking and
// full-coverage requirement for pass). Without it cov_map reads 0.
module or3_vector_checker
   import or3_chk_pkg::*;
#(
   parameter int VEC_COUNT = 8,
   parameter int CNT_W     = 8
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  vec_valid,
   input  logic                  in1,
   input  logic                  in2,
   input  logic                  in3,
   input  logic                  out_or,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  err_pulse,
   output logic [CNT_W-1:0]      err_cnt,
   output logic [CNT_W-1:0]      vec_cnt,
   output logic [CNT_W-1:0]      first_err_idx,
   output logic [NUM_COMBOS-1:0] cov_map
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_COUNT - 1);

   chk_state_t       state_q;
   chk_state_t       state_d;
   logic             accept;
   logic             launch;
   logic             last_vec;
   logic             mismatch_q;
   logic [CNT_W-1:0] idx_q;
   logic             cov_ok;

   assign accept   = (state_q == RUN) && vec_valid;
   assign launch   = start && ((state_q == IDLE) || (state_q == DONE));
   assign last_vec = accept && (vec_cnt == LAST_IDX);

   // State register; reset always lands in IDLE so no partial result is shown.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and status outputs.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      pass    = 1'b0;
      case (state_q)
         IDLE: begin
            if (launch) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_vec) state_d = DRAIN;
         end
         DRAIN: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done = 1'b1;
            pass = (err_cnt == '0) && cov_ok;
            if (launch) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Vector counting, registered mismatch and the error bookkeeping that
   // follows it one edge later, so err_cnt is final on entry to DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mismatch_q    <= 1'b0;
         idx_q         <= '0;
         vec_cnt       <= '0;
         err_cnt       <= '0;
         first_err_idx <= '0;
      end else if (launch) begin
         mismatch_q    <= 1'b0;
         idx_q         <= '0;
         vec_cnt       <= '0;
         err_cnt       <= '0;
         first_err_idx <= '0;
      end else begin
         mismatch_q <= accept && (out_or != exp_or(in1, in2, in3));
         if (accept) begin
            idx_q   <= vec_cnt;
            vec_cnt <= vec_cnt + CNT_W'(1);
         end
         if (mismatch_q) begin
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            if (err_cnt == '0) first_err_idx <= idx_q;
         end
      end
   end

   assign err_pulse = mismatch_q;

`ifdef OR3_CHK_COVERAGE_EN
   logic cov_all;

   or3_chk_cov u_cov (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (launch),
      .set_en      (accept),
      .sel         ({in3, in2, in1}),
      .cov_map     (cov_map),
      .all_covered (cov_all)
   );

   assign cov_ok = cov_all;
`else
   assign cov_map = '0;
   assign cov_ok  = 1'b1;
`endif

endmodule

// File: tb/tb_or3_vector_checker.sv
// Directed self-checking bench for or3_vector_checker (default instance
// plus a CNT_W=2/VEC_COUNT=4 instance for counter saturation).
module tb_or3_vector_checker;

   logic       clk = 1'b0;
   logic       rst_n, start, vec_valid, in1, in2, in3, out_or;
   logic       busy, done, pass, err_pulse;
   logic [7:0] err_cnt, vec_cnt, first_err_idx, cov_map;

   logic       sat_start, sat_valid, sat_in1, sat_in2, sat_in3, sat_out;
   logic       sat_busy, sat_done, sat_pass, sat_err_pulse;
   logic [1:0] sat_err_cnt, sat_vec_cnt, sat_first_err_idx;
   logic [7:0] sat_cov_map;

   int errors = 0;
   int checks = 0;

`ifdef OR3_CHK_COVERAGE_EN
   localparam logic [7:0] FULL_COV  = 8'hFF;
   localparam logic [7:0] HOLE_COV  = 8'hFE;
   localparam logic       HOLE_PASS = 1'b0;
`else
   localparam logic [7:0] FULL_COV  = 8'h00;
   localparam logic [7:0] HOLE_COV  = 8'h00;
   localparam logic       HOLE_PASS = 1'b1;
`endif

   always #5 clk = ~clk;

   or3_vector_checker #(.VEC_COUNT(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
      .in1(in1), .in2(in2), .in3(in3), .out_or(out_or),
      .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
      .err_cnt(err_cnt), .vec_cnt(vec_cnt), .first_err_idx(first_err_idx),
      .cov_map(cov_map)
   );

   or3_vector_checker #(.VEC_COUNT(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(sat_start), .vec_valid(sat_valid),
      .in1(sat_in1), .in2(sat_in2), .in3(sat_in3), .out_or(sat_out),
      .busy(sat_busy), .done(sat_done), .pass(sat_pass), .err_pulse(sat_err_pulse),
      .err_cnt(sat_err_cnt), .vec_cnt(sat_vec_cnt), .first_err_idx(sat_first_err_idx),
      .cov_map(sat_cov_map)
   );

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] bits, input logic o);
      vec_valid         = v;
      {in3, in2, in1}   = bits;
      out_or            = o;
      tick();
   endtask

   task automatic startRun();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Presents 8 vectors back to back; bad_mask selects inverted responses.
   task automatic runVectors(input logic [23:0] combos, input logic [7:0] bad_mask,
                             output int pulses, output int pulse_at);
      logic [2:0] bits;
      logic       expv;
      pulses   = 0;
      pulse_at = -1;
      for (int i = 0; i < 8; i++) begin
         bits = combos[i*3 +: 3];
         expv = |bits;
         applyStimulus(1'b1, bits, bad_mask[i] ? ~expv : expv);
         if (err_pulse) begin
            pulses++;
            if (pulse_at < 0) pulse_at = i;
         end
      end
      vec_valid = 1'b0;
      checkOutput("drain_busy", {31'd0, busy}, 32'd1);
      checkOutput("drain_done", {31'd0, done}, 32'd0);
      checkOutput("drain_vec_cnt", {24'd0, vec_cnt}, 32'd8);
      tick();
      if (err_pulse) pulses++;
   endtask

   logic [23:0] seq_full;
   logic [23:0] seq_hole;
   int          pulses, pulse_at;

   initial begin
      for (int i = 0; i < 8; i++) seq_full[i*3 +: 3] = 3'(i);
      seq_hole        = seq_full;
      seq_hole[2:0]   = 3'd7;

      rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0;
      in1 = 1'b0; in2 = 1'b0; in3 = 1'b0; out_or = 1'b0;
      sat_start = 1'b0; sat_valid = 1'b0;
      sat_in1 = 1'b0; sat_in2 = 1'b0; sat_in3 = 1'b0; sat_out = 1'b0;
      tick();
      tick();
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_pass", {31'd0, pass}, 32'd0);
      checkOutput("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
      checkOutput("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      checkOutput("rst_vec_cnt", {24'd0, vec_cnt}, 32'd0);
      checkOutput("rst_cov_map", {24'd0, cov_map}, 32'd0);
      rst_n = 1'b1;
      tick();

      $display("[TB] good run");
      startRun();
      checkOutput("good_start_busy", {31'd0, busy}, 32'd1);
      runVectors(seq_full, 8'h00, pulses, pulse_at);
      checkOutput("good_done", {31'd0, done}, 32'd1);
      checkOutput("good_busy", {31'd0, busy}, 32'd0);
      checkOutput("good_pass", {31'd0, pass}, 32'd1);
      checkOutput("good_err_cnt", {24'd0, err_cnt}, 32'd0);
      checkOutput("good_cov_map", {24'd0, cov_map}, {24'd0, FULL_COV});
      checkOutput("good_pulses", pulses, 32'd0);
      tick();
      checkOutput("good_done_holds", {31'd0, done}, 32'd1);

      $display("[TB] fault on vector 5, restarted from DONE");
      startRun();
      checkOutput("restart_done", {31'd0, done}, 32'd0);
      checkOutput("restart_vec_cnt", {24'd0, vec_cnt}, 32'd0);
      checkOutput("restart_cov_map", {24'd0, cov_map}, 32'd0);
      runVectors(seq_full, 8'h20, pulses, pulse_at);
      checkOutput("fault_pulses", pulses, 32'd1);
      checkOutput("fault_pulse_at", pulse_at, 32'd5);
      checkOutput("fault_done", {31'd0, done}, 32'd1);
      checkOutput("fault_err_cnt", {24'd0, err_cnt}, 32'd1);
      checkOutput("fault_first_idx", {24'd0, first_err_idx}, 32'd5);
      checkOutput("fault_pass", {31'd0, pass}, 32'd0);

      $display("[TB] coverage hole");
      startRun();
      checkOutput("hole_start_err_cnt", {24'd0, err_cnt}, 32'd0);
      runVectors(seq_hole, 8'h00, pulses, pulse_at);
      checkOutput("hole_done", {31'd0, done}, 32'd1);
      checkOutput("hole_err_cnt", {24'd0, err_cnt}, 32'd0);
      checkOutput("hole_cov_map", {24'd0, cov_map}, {24'd0, HOLE_COV});
      checkOutput("hole_pass", {31'd0, pass}, {31'd0, HOLE_PASS});

      $display("[TB] reset mid-run");
      startRun();
      applyStimulus(1'b1, 3'd1, 1'b1);
      applyStimulus(1'b1, 3'd2, 1'b0);
      applyStimulus(1'b1, 3'd3, 1'b1);
      vec_valid = 1'b0;
      checkOutput("mid_vec_cnt", {24'd0, vec_cnt}, 32'd3);
      checkOutput("mid_err_cnt", {24'd0, err_cnt}, 32'd1);
      rst_n = 1'b0;
      tick();
      checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
      checkOutput("mid_rst_pass", {31'd0, pass}, 32'd0);
      checkOutput("mid_rst_err_pulse", {31'd0, err_pulse}, 32'd0);
      checkOutput("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      checkOutput("mid_rst_vec_cnt", {24'd0, vec_cnt}, 32'd0);
      checkOutput("mid_rst_first_idx", {24'd0, first_err_idx}, 32'd0);
      checkOutput("mid_rst_cov_map", {24'd0, cov_map}, 32'd0);
      rst_n = 1'b1;
      tick();

      $display("[TB] start coincident with vec_valid in IDLE");
      start = 1'b1;
      vec_valid = 1'b1;
      {in3, in2, in1} = 3'd3;
      out_or = 1'b1;
      tick();
      start = 1'b0;
      vec_valid = 1'b0;
      checkOutput("coinc_vec_cnt", {24'd0, vec_cnt}, 32'd0);
      checkOutput("coinc_busy", {31'd0, busy}, 32'd1);
      checkOutput("coinc_cov_map", {24'd0, cov_map}, 32'd0);
      runVectors(seq_full, 8'h00, pulses, pulse_at);
      checkOutput("fresh_done", {31'd0, done}, 32'd1);
      checkOutput("fresh_pass", {31'd0, pass}, 32'd1);

      $display("[TB] error counter saturation");
      sat_start = 1'b1;
      tick();
      sat_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sat_valid = 1'b1;
         {sat_in3, sat_in2, sat_in1} = 3'(k);
         sat_out = ~(|3'(k));
         tick();
         checkOutput($sformatf("sat_err_cnt_%0d", k), {30'd0, sat_err_cnt}, k);
      end
      sat_valid = 1'b0;
      tick();
      checkOutput("sat_final_err_cnt", {30'd0, sat_err_cnt}, 32'd3);
      checkOutput("sat_done", {31'd0, sat_done}, 32'd1);
      checkOutput("sat_pass", {31'd0, sat_pass}, 32'd0);
      checkOutput("sat_first_idx", {30'd0, sat_first_err_idx}, 32'd0);
      tick();
      checkOutput("sat_no_wrap", {30'd0, sat_err_cnt}, 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
